// File: rtl/event_enable_gen.sv
// event_enable_gen: turns a raw, bouncing, asynchronous event level into clean
// single-cycle count-enable pulses for the downstream 4-bit counter.
// Path: 2-flop synchronizer -> symmetric debounce FSM -> gated rising-edge pulse.
// Optional feature: define EVT_PRESCALE_EN to pulse only on every PRESCALE-th
// enabled rising event; without it PRESCALE is ignored and no prescaler is built.
module event_enable_gen #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 8,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic evt_in,
  input  logic enable,
  output logic cnt_en,
  output logic evt_level
);

  typedef enum logic [1:0] {
    StLow,
    StRiseChk,
    StHigh,
    StFallChk
  } state_e;

  localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DbOne  = DB_W'(1);

  // Reject parameter values that would break the debounce or prescale logic.
  if (DB_CYCLES < 2 || DB_CYCLES > (2 ** DB_W) - 1) begin : g_bad_db_cycles
    $error("event_enable_gen: DB_CYCLES out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 16) begin : g_bad_prescale
    $error("event_enable_gen: PRESCALE out of range");
  end

  logic            sync1_q, sync2_q;
  logic            s_evt;
  state_e          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise_acc;
  logic            cnt_en_q, cnt_en_d;
  logic            evt_level_q, evt_level_d;

  assign s_evt = sync2_q;

  // Two-flop synchronizer for the asynchronous event input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= evt_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next-state: a level change is accepted after DB_CYCLES equal samples.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    rise_acc = 1'b0;
    case (state_q)
      StLow: begin
        if (s_evt) begin
          state_d  = StRiseChk;
          db_cnt_d = DbOne;
        end
      end
      StRiseChk: begin
        if (!s_evt) begin
          state_d  = StLow;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          state_d  = StHigh;
          db_cnt_d = '0;
          rise_acc = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      StHigh: begin
        if (!s_evt) begin
          state_d  = StFallChk;
          db_cnt_d = DbOne;
        end
      end
      StFallChk: begin
        if (s_evt) begin
          state_d  = StHigh;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          state_d  = StLow;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      default: begin
        state_d  = StLow;
        db_cnt_d = '0;
      end
    endcase
  end

  // Level output tracks the state being registered at the same edge.
  always_comb begin
    evt_level_d = (state_d == StHigh) || (state_d == StFallChk);
  end

`ifdef EVT_PRESCALE_EN
  localparam logic [3:0] PresLast = 4'(PRESCALE - 1);

  logic [3:0] presc_q, presc_d;

  // Prescaler: only enabled accepted events advance it; pulse on the wrapping event.
  always_comb begin
    presc_d  = presc_q;
    cnt_en_d = 1'b0;
    if (rise_acc && enable) begin
      if (presc_q == PresLast) begin
        presc_d  = '0;
        cnt_en_d = 1'b1;
      end else begin
        presc_d = presc_q + 4'd1;
      end
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Every enabled accepted rising event pulses; a disabled one is dropped, not deferred.
  always_comb begin
    cnt_en_d = rise_acc & enable;
  end
`endif

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StLow;
      db_cnt_q    <= '0;
      cnt_en_q    <= 1'b0;
      evt_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      cnt_en_q    <= cnt_en_d;
      evt_level_q <= evt_level_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign evt_level = evt_level_q;

endmodule

// File: doc/event_enable_gen.md
# event_enable_gen

Conditions a raw, asynchronous event input into clean single-cycle count-enable pulses. It sits directly upstream of the 4-bit synchronous counter and drives that counter's `cnt_en` input. The input path is:

- a 2-flop synchronizer;
- a symmetric debounce state machine;
- a rising-edge pulse generator with an enable gate.

## Interface

Parameters:
- `DB_CYCLES`, default 4: consecutive synchronized samples required to accept a level change. Legal range 2..2^DB_W-1.
- `DB_W`, default 8: width of the debounce counter.
- `PRESCALE`, default 4: event divide ratio, legal range 1..16. Used only when `EVT_PRESCALE_EN` is defined.

Ports (clock and reset first):
- `clk`  input  1  single clock for the whole block.
- `rstn`  input  1  reset, asynchronous, active-low.
- `evt_in`  input  1  raw event level, asynchronous to `clk`, may bounce.
- `enable`  input  1  pulse gate; 0 suppresses `cnt_en`.
- `cnt_en`  output  1  registered, one-cycle pulse per accepted rising event.
- `evt_level`  output  1  registered debounced level.

## Operation

- **Synchronizer:** `evt_in` passes through `sync1` then `sync2`. `s_evt = sync2`. The FSM samples only `s_evt`.
- **FSM states:** LOW, RISE_CHK, HIGH, FALL_CHK. `db_cnt` is DB_W bits wide.
- **LOW:**
  - `s_evt`=1: go to RISE_CHK, `db_cnt`<=1.
  - Otherwise stay in LOW.
- **RISE_CHK:**
  - `s_evt`=0: go to LOW, `db_cnt`<=0. The glitch is discarded and no pulse is issued.
  - `s_evt`=1 and `db_cnt`==DB_CYCLES-1: go to HIGH, `db_cnt`<=0, and issue an accepted rising event.
  - `s_evt`=1 otherwise: `db_cnt`<=`db_cnt`+1.
- **HIGH:**
  - `s_evt`=0: go to FALL_CHK, `db_cnt`<=1.
  - Otherwise stay in HIGH.
- **FALL_CHK:** mirror of RISE_CHK with polarity inverted.
  - Return to HIGH on `s_evt`=1.
  - Go to LOW after DB_CYCLES consecutive zero samples.
  - No pulse on falling events.
- **`evt_level`:** 1 exactly while the state is HIGH or FALL_CHK. It is registered with the state.
- **`cnt_en` on an accepted rising event:** `cnt_en`<=`enable` at the same edge as the transition to HIGH. It returns to 0 at the next edge.
- **Pulse spacing:** two pulses are always at least 2*DB_CYCLES cycles apart. `cnt_en` is never high on two consecutive cycles.
- **`enable`=0:** the FSM keeps tracking the input. Pulses are suppressed and not deferred. Re-enabling while the input is held high does not produce a pulse.
- **`db_cnt` width:** never exceeds DB_CYCLES-1. There is no wrap-around.

## Timing

- **Reset values:** `rstn`=0 asynchronously clears the following. No output glitches to 1 during reset.
  - `sync1`, `sync2`, `db_cnt` = 0
  - state = LOW
  - `cnt_en` = 0
  - `evt_level` = 0
  - prescale counter = 0
- **Rising latency:** let E be the first edge that samples `evt_in`=1 with the input stable afterwards.
  - `sync2` goes high at E+1.
  - The FSM enters RISE_CHK at E+2.
  - The FSM enters HIGH at E+DB_CYCLES+1.
  - `cnt_en` and `evt_level` go high after edge E+DB_CYCLES+1. `cnt_en` falls at E+DB_CYCLES+2.
  - The counter downstream increments at edge E+DB_CYCLES+2.
- **Falling latency:** `evt_level` falls after edge F+DB_CYCLES+1, with F defined the same way for `evt_in`=0.
- **Reset mid-operation:** debounce progress is lost and no pulse is issued. If `evt_in` is held high through reset release, a new pulse follows the full rising latency, measured from the first post-reset edge.
- **Simultaneous events:** a transition into HIGH and `enable` falling at the same edge: the sampled `enable` value decides. An `enable` that is 0 at the edge suppresses the pulse.

## Configuration

- **Macro:** `EVT_PRESCALE_EN`.
- **With the macro defined:**
  - A 4-bit prescale counter counts accepted rising events that occur while `enable`=1.
  - `cnt_en` pulses only on the event where the counter equals PRESCALE-1. The counter then wraps to 0.
  - Events with `enable`=0 neither pulse nor advance the counter.
  - PRESCALE=1 behaves like the macro-off build.
- **Without the macro:** every enabled accepted rising event pulses. `PRESCALE` is ignored, and the prescale logic must not be synthesized.

## Test plan

- **Clean event:** DB_CYCLES=4, `enable`=1, `evt_in` set to 1 before edge 0 and held. Required: `cnt_en` is 1 only between edges 5 and 6, and `evt_level` goes high after edge 5.
- **Glitch rejection:** `evt_in` high for 3 cycles, then low. Required: `cnt_en` and `evt_level` stay 0, and the FSM returns to LOW.
- **Bounce then settle:** a 1-0-1-1-0 bounce, then held high for 10 cycles. Required: exactly one `cnt_en` pulse. A subsequent bounce on the falling side produces no pulse.
- **Enable gating:** event accepted while `enable`=0, then `enable` set to 1 while `evt_in` is still high. Required: no pulse. The next full event pulses once.
- **Reset mid-debounce:** `rstn` pulsed low while in RISE_CHK with `evt_in` held high. Required: all outputs read 0 immediately, then one pulse DB_CYCLES+2 edges after release.
- **Prescale (`EVT_PRESCALE_EN`, PRESCALE=4):** 9 clean events with `enable`=1. Required: pulses on events 4 and 8 only.
